line_setup: RTL and testbench

- Stage directly upstream of the line rasterizer.
- Accepts clipped line endpoints plus colour from the clipper over a valid/ready handshake.
- Computes signed deltas, slope sign and steepness, and packs one 69-bit line word per line.
- Words are buffered in an internal show-ahead FIFO, which the rasterizer drains through fifo_data/fifo_empty/fifo_rd_en.

---
 rtl/line_setup.sv | 170 +++++++++++++++++
 tb/tb_line_setup.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_setup.sv
// Line setup stage feeding the rasterizer: two-stage delta/slope pipeline that packs one
// 69-bit line word per accepted line into a show-ahead FIFO with credit-based backpressure.
module line_setup #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned X_MAX = 639,
    parameter int unsigned Y_MAX = 479
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [9:0]    in_x0,
    input  logic [9:0]    in_y0,
    input  logic [9:0]    in_x1,
    input  logic [9:0]    in_y1,
    input  logic [2:0]    in_color,
    input  logic          in_draw,
    input  logic          flush,
    input  logic          fifo_rd_en,
    output logic [68:0]   fifo_data,
    output logic          fifo_empty,
    output logic [AW:0]   fifo_count,
    output logic          overflow
);

    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW+1:0] DEPTH_CRD = (AW+2)'(DEPTH);
    localparam logic [9:0]    X_LIM     = 10'(X_MAX);
    localparam logic [9:0]    Y_LIM     = 10'(Y_MAX);

    // Stage 1 registers
    logic        r_s1_v;
    logic [9:0]  r_s1_x0, r_s1_y0, r_s1_x1, r_s1_y1;
    logic [2:0]  r_s1_color;
    logic        r_s1_draw;
    logic        r_s1_range_ok;
    logic [10:0] r_s1_dx, r_s1_dy;

    // Stage 2 registers
    logic        r_s2_v;
    logic [68:0] r_s2_word;

    // FIFO state
    logic [68:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;

    logic          w_accept;
    logic [AW+1:0] w_credits;
    logic [10:0]   w_dx, w_dy;
    logic          w_range_ok;
    logic [10:0]   w_adx, w_ady;
    logic [68:0]   w_word;
    logic          w_full;
    logic          w_rd;
    logic          w_drop;
    logic          w_wr;

    // Lines in flight count against FIFO space so a stage-2 write never meets a full FIFO.
    assign w_credits = {1'b0, r_count} + (AW+2)'(r_s1_v) + (AW+2)'(r_s2_v);
    assign in_ready  = (w_credits < DEPTH_CRD) & ~flush & ~rst;
    assign w_accept  = in_valid & in_ready;

    assign w_dx       = {1'b0, in_x1} - {1'b0, in_x0};
    assign w_dy       = {1'b0, in_y1} - {1'b0, in_y0};
    assign w_range_ok = (in_x0 <= X_LIM) & (in_x1 <= X_LIM) &
                        (in_y0 <= Y_LIM) & (in_y1 <= Y_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v        <= 1'b0;
            r_s1_x0       <= '0;
            r_s1_y0       <= '0;
            r_s1_x1       <= '0;
            r_s1_y1       <= '0;
            r_s1_color    <= '0;
            r_s1_draw     <= 1'b0;
            r_s1_range_ok <= 1'b0;
            r_s1_dx       <= '0;
            r_s1_dy       <= '0;
        end else if (flush) begin
            r_s1_v <= 1'b0;
        end else begin
            r_s1_v <= w_accept;
            if (w_accept) begin
                r_s1_x0       <= in_x0;
                r_s1_y0       <= in_y0;
                r_s1_x1       <= in_x1;
                r_s1_y1       <= in_y1;
                r_s1_color    <= in_color;
                r_s1_draw     <= in_draw;
                r_s1_range_ok <= w_range_ok;
                r_s1_dx       <= w_dx;
                r_s1_dy       <= w_dy;
            end
        end
    end

    // |-1024| cannot occur: 10-bit unsigned operands bound deltas to +/-1023.
    assign w_adx = r_s1_dx[10] ? (11'd0 - r_s1_dx) : r_s1_dx;
    assign w_ady = r_s1_dy[10] ? (11'd0 - r_s1_dy) : r_s1_dy;

    assign w_word = {r_s1_x0, r_s1_y0, r_s1_x1, r_s1_y1,
                     r_s1_dy, r_s1_dx, r_s1_color,
                     r_s1_draw & r_s1_range_ok,
                     w_ady > w_adx,
                     1'b0,
                     r_s1_dx[10] ^ r_s1_dy[10]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_v    <= 1'b0;
            r_s2_word <= '0;
        end else if (flush) begin
            r_s2_v <= 1'b0;
        end else begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_word <= w_word;
            end
        end
    end

    assign w_full = (r_count == DEPTH_CNT);
    assign w_rd   = fifo_rd_en & (r_count != '0);
    assign w_drop = r_s2_v & w_full & ~w_rd;
    assign w_wr   = r_s2_v & ~w_drop;

    always_ff @(posedge clk) begin
        if (w_wr && !flush) begin
            r_mem[r_wr_ptr] <= r_s2_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_wr && !w_rd) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_wr && w_rd) begin
                r_count <= r_count - (AW+1)'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign fifo_empty = (r_count == '0);
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign fifo_data  = fifo_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: tb/tb_line_setup.sv
// Scoreboard bench for line_setup: directed lines push expected words into a queue, a
// monitor pops and compares on every read of a non-empty FIFO.
module tb_line_setup;

    typedef struct packed {
        logic [9:0] x0;
        logic [9:0] y0;
        logic [9:0] x1;
        logic [9:0] y1;
        logic [2:0] c;
        logic       d;
    } line_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_x0, in_y0, in_x1, in_y1;
    logic [2:0]  in_color;
    logic        in_draw;
    logic        flush;
    logic        fifo_rd_en;
    logic [68:0] fifo_data;
    logic        fifo_empty;
    logic [4:0]  fifo_count;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [68:0] sb[$];

    line_setup #(.DEPTH(16), .AW(4), .X_MAX(639), .Y_MAX(479)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x0      (in_x0),
        .in_y0      (in_y0),
        .in_x1      (in_x1),
        .in_y1      (in_y1),
        .in_color   (in_color),
        .in_draw    (in_draw),
        .flush      (flush),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [68:0] got, input logic [68:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic line_t mk(input int x0, input int y0, input int x1, input int y1,
                                 input int c, input int d);
        line_t l;
        l.x0 = 10'(x0);
        l.y0 = 10'(y0);
        l.x1 = 10'(x1);
        l.y1 = 10'(y1);
        l.c  = 3'(c);
        l.d  = (d != 0);
        return l;
    endfunction

    // Reference word built from integer arithmetic on the endpoints.
    function automatic logic [68:0] model(input line_t l);
        int dxi, dyi, adx, ady;
        logic [10:0] dx, dy;
        logic vld, stp, pn;
        dxi = int'(l.x1) - int'(l.x0);
        dyi = int'(l.y1) - int'(l.y0);
        dx  = dxi[10:0];
        dy  = dyi[10:0];
        adx = (dxi < 0) ? -dxi : dxi;
        ady = (dyi < 0) ? -dyi : dyi;
        stp = (ady > adx);
        pn  = (dxi < 0) != (dyi < 0);
        vld = l.d && (l.x0 <= 639) && (l.x1 <= 639) && (l.y0 <= 479) && (l.y1 <= 479);
        return {l.x0, l.y0, l.x1, l.y1, dy, dx, l.c, vld, stp, 1'b0, pn};
    endfunction

    function automatic line_t sline(input int i);
        return mk((i * 37) % 640, (i * 23) % 480, (i * 13 + 100) % 640,
                  (i * 11 + 7) % 480, i % 8, 1);
    endfunction

    // One clock cycle of stimulus, driven on the falling edge.
    task automatic cyc(input logic v, input line_t l, input logic rd, output logic acc);
        @(negedge clk);
        in_valid   = v;
        in_x0      = l.x0;
        in_y0      = l.y0;
        in_x1      = l.x1;
        in_y1      = l.y1;
        in_color   = l.c;
        in_draw    = l.d;
        fifo_rd_en = rd;
        acc = v & in_ready;
        if (acc) sb.push_back(model(l));
        #1;
    endtask

    task automatic idle(input int n);
        logic a;
        line_t z;
        z = '0;
        for (int i = 0; i < n; i++) cyc(1'b0, z, 1'b0, a);
    endtask

    task automatic drain();
        logic a;
        line_t z;
        int guard;
        z = '0;
        guard = 0;
        idle(3);
        while (!fifo_empty && guard < 40) begin
            cyc(1'b0, z, 1'b1, a);
            guard++;
        end
        cyc(1'b0, z, 1'b0, a);
        chk("drain_empty", 69'(fifo_empty), 69'(1));
        chk("drain_sb_empty", 69'(sb.size()), 69'(0));
    endtask

    always @(negedge clk) begin
        #1;
        if (!rst && fifo_rd_en && !fifo_empty) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_unexpected: got %h expected no word", fifo_data);
            end else begin
                chk("pop_data", fifo_data, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a;
        line_t z, la, lb, lc;
        logic [68:0] w;
        int nacc;
        z = '0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; fifo_rd_en = 1'b0;
        in_x0 = '0; in_y0 = '0; in_x1 = '0; in_y1 = '0; in_color = '0; in_draw = 1'b0;
        #1;
        chk("rst_in_ready", 69'(in_ready), 69'(0));
        chk("rst_empty", 69'(fifo_empty), 69'(1));
        chk("rst_count", 69'(fifo_count), 69'(0));
        chk("rst_overflow", 69'(overflow), 69'(0));
        chk("rst_data", fifo_data, 69'(0));
        #20;
        @(negedge clk) rst = 1'b0;
        #1;
        chk("post_rst_ready", 69'(in_ready), 69'(1));

        // Basic packing with 2-cycle visibility
        la = mk(10, 20, 110, 70, 5, 1);
        cyc(1'b1, la, 1'b0, a);
        cyc(1'b0, z, 1'b0, a);
        chk("A_empty_n1", 69'(fifo_empty), 69'(1));
        cyc(1'b0, z, 1'b0, a);
        chk("A_empty_n2", 69'(fifo_empty), 69'(1));
        cyc(1'b0, z, 1'b1, a);
        w = fifo_data;
        chk("A_visible", 69'(fifo_empty), 69'(0));
        chk("A_dx", 69'(w[17:7]), 69'(100));
        chk("A_dy", 69'(w[28:18]), 69'(50));
        chk("A_flags", 69'(w[3:0]), 69'(4'b1000));
        chk("A_color", 69'(w[6:4]), 69'(5));

        // Negative / steep and negative slope with zero dy
        lb = mk(300, 400, 290, 100, 2, 1);
        cyc(1'b1, lb, 1'b0, a);
        idle(2);
        cyc(1'b0, z, 1'b1, a);
        w = fifo_data;
        chk("B_dx", 69'(w[17:7]), 69'(11'h7F6));
        chk("B_dy", 69'(w[28:18]), 69'(11'h6D4));
        chk("B_flags", 69'(w[3:0]), 69'(4'b1100));
        lc = mk(5, 0, 0, 0, 7, 1);
        cyc(1'b1, lc, 1'b0, a);
        idle(2);
        cyc(1'b0, z, 1'b1, a);
        w = fifo_data;
        chk("C_dx", 69'(w[17:7]), 69'(11'h7FB));
        chk("C_dy", 69'(w[28:18]), 69'(0));
        chk("C_flags", 69'(w[3:0]), 69'(4'b1001));
        // Degenerate line
        cyc(1'b1, mk(42, 42, 42, 42, 1, 1), 1'b0, a);
        idle(2);
        cyc(1'b0, z, 1'b1, a);
        chk("D0_word", fifo_data, {10'd42, 10'd42, 10'd42, 10'd42, 22'd0, 3'd1, 4'b1000});
        drain();

        // Rejected and out-of-range lines keep their slot
        cyc(1'b1, mk(10, 10, 20, 20, 1, 0), 1'b0, a);
        cyc(1'b1, mk(5, 5, 700, 5, 2, 1), 1'b0, a);
        cyc(1'b1, mk(639, 479, 0, 0, 3, 1), 1'b0, a);
        idle(3);
        chk("inv_count", 69'(fifo_count), 69'(3));
        cyc(1'b0, z, 1'b1, a);
        chk("inv_draw0_valid", 69'(fifo_data[3]), 69'(0));
        cyc(1'b0, z, 1'b1, a);
        chk("inv_range_valid", 69'(fifo_data[3]), 69'(0));
        cyc(1'b0, z, 1'b1, a);
        chk("edge_valid", 69'(fifo_data[3]), 69'(1));
        drain();

        // Backpressure: only DEPTH credits
        nacc = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, sline(i), 1'b0, a);
            if (a) nacc++;
        end
        chk("bp_accepted", 69'(nacc), 69'(16));
        idle(3);
        chk("bp_count", 69'(fifo_count), 69'(16));
        chk("bp_ready", 69'(in_ready), 69'(0));
        chk("bp_overflow", 69'(overflow), 69'(0));
        cyc(1'b1, sline(20), 1'b1, a);
        chk("bp_pop_cycle_acc", 69'(a), 69'(0));
        cyc(1'b1, sline(21), 1'b0, a);
        chk("bp_ready_rise", 69'(a), 69'(1));
        nacc = 0;
        for (int i = 22; i < 26; i++) begin
            cyc(1'b1, sline(i), 1'b0, a);
            if (a) nacc++;
        end
        chk("bp_extra", 69'(nacc), 69'(0));
        idle(3);
        chk("bp_count2", 69'(fifo_count), 69'(16));
        chk("bp_overflow2", 69'(overflow), 69'(0));
        drain();

        // Simultaneous push/pop at occupancy 3
        for (int i = 0; i < 3; i++) cyc(1'b1, sline(30 + i), 1'b0, a);
        idle(3);
        chk("sim_count_init", 69'(fifo_count), 69'(3));
        nacc = 0;
        for (int k = 0; k < 52; k++) begin
            cyc(1'b1, sline(40 + k), (k >= 2), a);
            if (a) nacc++;
            if (fifo_count != 5'd3) chk("sim_count", 69'(fifo_count), 69'(3));
        end
        chk("sim_count_end", 69'(fifo_count), 69'(3));
        chk("sim_accepted", 69'(nacc), 69'(52));
        drain();
        cyc(1'b0, z, 1'b1, a);
        cyc(1'b0, z, 1'b0, a);
        chk("rd_empty_count", 69'(fifo_count), 69'(0));

        // Flush with 5 stored and 2 in flight
        for (int i = 0; i < 5; i++) cyc(1'b1, sline(100 + i), 1'b0, a);
        idle(3);
        chk("fl_count5", 69'(fifo_count), 69'(5));
        cyc(1'b1, sline(105), 1'b0, a);
        cyc(1'b1, sline(106), 1'b0, a);
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b1;
        #1;
        chk("fl_ready", 69'(in_ready), 69'(0));
        sb.delete();
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fl_count", 69'(fifo_count), 69'(0));
        chk("fl_empty", 69'(fifo_empty), 69'(1));
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, z, 1'b0, a);
            chk("fl_no_stale", 69'(fifo_empty), 69'(1));
        end
        chk("fl_overflow", 69'(overflow), 69'(0));

        // Asynchronous reset between edges
        for (int i = 0; i < 3; i++) cyc(1'b1, sline(200 + i), 1'b0, a);
        idle(1);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 69'(fifo_count), 69'(0));
        chk("arst_empty", 69'(fifo_empty), 69'(1));
        chk("arst_ready", 69'(in_ready), 69'(0));
        chk("arst_data", fifo_data, 69'(0));
        sb.delete();
        @(negedge clk) rst = 1'b0;
        idle(4);
        chk("arst_still_empty", 69'(fifo_empty), 69'(1));
        cyc(1'b1, sline(300), 1'b0, a);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
